blink_meter: RTL and testbench

Measures the high and low durations of a single-bit periodic input in clock cycles and reports them as 32-bit values split into 16-bit words, with a one-cycle CPU interrupt per completed period. It is the receive-side counterpart of the LED blinker application: it sits on a sensor or GPIO input bit, and its outputs map one-to-one onto the blinker's period words.

---
 rtl/blink_meter.sv | 206 ++++++++++++++++++++
 tb/tb_blink_meter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_meter.sv
// blink_meter
// Measures the high and low durations (in Clk_i cycles) of an asynchronous
// periodic input bit. Each completed period (high phase followed by low phase,
// closed by the next rising edge) is published as two 32-bit values split into
// 16-bit words, together with a one-cycle CpuIntr_o pulse. Measurement is
// continuous: the rising edge that closes one period opens the next.
//
// Optional feature macro: BLINK_METER_TIMEOUT_EN
//   Adds TimeoutH_i/TimeoutL_i (32-bit limit, 0 = off) and the sticky Timeout_o
//   flag. A phase reaching the limit pulses CpuIntr_o and re-arms the meter.
//
// Parameters
//   SyncStages   synchronizer depth on Input_i (2..3)
// Ports
//   Clk_i        system clock, rising edge
//   Reset_i      asynchronous active-high reset
//   Enable_i     measurement enable (level)
//   Input_i      asynchronous bit to measure
//   HighTimeH_o  high duration [31:16]
//   HighTimeL_o  high duration [15:0]
//   LowTimeH_o   low duration [31:16]
//   LowTimeL_o   low duration [15:0]
//   CpuIntr_o    one-cycle pulse on new result (or timeout)
//   TimeoutH_i   timeout limit [31:16]   (macro only)
//   TimeoutL_i   timeout limit [15:0]    (macro only)
//   Timeout_o    sticky timeout flag     (macro only)
module blink_meter #(
    parameter int SyncStages = 2
) (
    input  logic        Clk_i,
    input  logic        Reset_i,
    input  logic        Enable_i,
    input  logic        Input_i,
`ifdef BLINK_METER_TIMEOUT_EN
    input  logic [15:0] TimeoutH_i,
    input  logic [15:0] TimeoutL_i,
    output logic        Timeout_o,
`endif
    output logic [15:0] HighTimeH_o,
    output logic [15:0] HighTimeL_o,
    output logic [15:0] LowTimeH_o,
    output logic [15:0] LowTimeL_o,
    output logic        CpuIntr_o
);

`ifdef BLINK_METER_TIMEOUT_EN
    typedef enum logic [2:0] {stDisabled, stArm, stHigh, stLow, stTimeout} state_t;
`else
    typedef enum logic [1:0] {stDisabled, stArm, stHigh, stLow} state_t;
`endif

    state_t              r_state, w_state_nxt;
    logic [SyncStages-1:0] r_sync;
    logic                r_sd;
    logic [31:0]         r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [31:0]         r_high, w_high_nxt;
    logic [31:0]         r_res_high, r_res_low;
    logic                r_intr, w_intr_nxt;
    logic                w_pub;
    logic                w_s, w_rise, w_fall;

    assign w_s    = r_sync[SyncStages-1];
    assign w_rise = w_s & ~r_sd;
    assign w_fall = ~w_s & r_sd;

    // Counter saturates rather than wraps so a stuck input reads as "very long".
    assign w_cnt_inc = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;

`ifdef BLINK_METER_TIMEOUT_EN
    logic        r_timeout, w_to_set, w_to_clr, w_to_hit;
    logic [31:0] w_limit;
    assign w_limit  = {TimeoutH_i, TimeoutL_i};
    assign w_to_hit = (w_limit != 32'd0) && (r_cnt == w_limit);
    assign Timeout_o = r_timeout;
`endif

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) r_state <= stDisabled;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_high_nxt  = r_high;
        w_intr_nxt  = 1'b0;
        w_pub       = 1'b0;
`ifdef BLINK_METER_TIMEOUT_EN
        w_to_set    = 1'b0;
        w_to_clr    = 1'b0;
`endif
        if (!Enable_i) begin
            // Disable overrides any edge seen in the same cycle.
            w_state_nxt = stDisabled;
            w_cnt_nxt   = 32'd0;
`ifdef BLINK_METER_TIMEOUT_EN
            w_to_clr    = 1'b1;
`endif
        end else begin
            case (r_state)
                stDisabled: begin
                    w_state_nxt = stArm;
                    w_cnt_nxt   = 32'd0;
                end
                // A level already high here is ignored: only a real Rise
                // (preceded by a low) starts a measurement.
                stArm: begin
                    if (w_rise) begin
                        w_cnt_nxt   = 32'd1;
                        w_state_nxt = stHigh;
                    end
                end
`ifdef BLINK_METER_TIMEOUT_EN
                stTimeout: begin
                    if (w_rise) begin
                        w_cnt_nxt   = 32'd1;
                        w_state_nxt = stHigh;
                    end
                end
`endif
                stHigh: begin
                    if (w_fall) begin
                        w_high_nxt  = r_cnt;
                        w_cnt_nxt   = 32'd1;
                        w_state_nxt = stLow;
                    end
`ifdef BLINK_METER_TIMEOUT_EN
                    else if (w_to_hit) begin
                        w_intr_nxt  = 1'b1;
                        w_to_set    = 1'b1;
                        w_cnt_nxt   = 32'd0;
                        w_state_nxt = stTimeout;
                    end
`endif
                    else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                stLow: begin
                    // The closing Rise is also the first cycle of the next high.
                    if (w_rise) begin
                        w_pub       = 1'b1;
                        w_intr_nxt  = 1'b1;
                        w_cnt_nxt   = 32'd1;
                        w_state_nxt = stHigh;
`ifdef BLINK_METER_TIMEOUT_EN
                        w_to_clr    = 1'b1;
`endif
                    end
`ifdef BLINK_METER_TIMEOUT_EN
                    else if (w_to_hit) begin
                        w_intr_nxt  = 1'b1;
                        w_to_set    = 1'b1;
                        w_cnt_nxt   = 32'd0;
                        w_state_nxt = stTimeout;
                    end
`endif
                    else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = stDisabled;
                    w_cnt_nxt   = 32'd0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            r_sync     <= '0;
            r_sd       <= 1'b0;
            r_cnt      <= 32'd0;
            r_high     <= 32'd0;
            r_res_high <= 32'd0;
            r_res_low  <= 32'd0;
            r_intr     <= 1'b0;
        end else begin
            r_sync <= {r_sync[SyncStages-2:0], Input_i};
            r_sd   <= w_s;
            r_cnt  <= w_cnt_nxt;
            r_high <= w_high_nxt;
            r_intr <= w_intr_nxt;
            if (w_pub) begin
                r_res_high <= r_high;
                r_res_low  <= r_cnt;
            end
        end
    end

`ifdef BLINK_METER_TIMEOUT_EN
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i)       r_timeout <= 1'b0;
        else if (w_to_clr) r_timeout <= 1'b0;
        else if (w_to_set) r_timeout <= 1'b1;
    end
`endif

    assign HighTimeH_o = r_res_high[31:16];
    assign HighTimeL_o = r_res_high[15:0];
    assign LowTimeH_o  = r_res_low[31:16];
    assign LowTimeL_o  = r_res_low[15:0];
    assign CpuIntr_o   = r_intr;

endmodule

// File: tb/tb_blink_meter.sv
module tb_blink_meter;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst, en, din;
    logic [15:0] hth, htl, lth, ltl;
    logic        intr;
`ifdef BLINK_METER_TIMEOUT_EN
    logic [15:0] toh = 16'd0, tol = 16'd0;
    logic        tof;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    blink_meter #(.SyncStages(SS)) dut (
        .Clk_i       (clk),
        .Reset_i     (rst),
        .Enable_i    (en),
        .Input_i     (din),
`ifdef BLINK_METER_TIMEOUT_EN
        .TimeoutH_i  (toh),
        .TimeoutL_i  (tol),
        .Timeout_o   (tof),
`endif
        .HighTimeH_o (hth),
        .HighTimeL_o (htl),
        .LowTimeH_o  (lth),
        .LowTimeL_o  (ltl),
        .CpuIntr_o   (intr)
    );

    // Reference model: works on edge times. An input transition sampled at
    // edge k takes effect at edge k+SS. A measurement opens at a rise time r,
    // the fall time f closes the high phase (f-r), and the next rise t
    // publishes (f-r, t-f). Disable kills the measurement; the first enabled
    // edge after a disable only arms.
    bit          smp[0:SS+1];
    bit          m_dis = 1'b1, m_hr = 1'b0, m_hf = 1'b0, m_rise, m_fall;
    int          m_t = 0, m_r = 0, m_f = 0, m_lim = 0;
    logic [31:0] e_hi = 32'd0, e_lo = 32'd0;
    logic        e_intr = 1'b0, e_to = 1'b0;

    initial begin : model
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int j = 0; j <= SS + 1; j++) smp[j] = 1'b0;
                m_dis = 1'b1; m_hr = 1'b0; m_hf = 1'b0; m_t = 0;
                e_hi = 32'd0; e_lo = 32'd0; e_intr = 1'b0; e_to = 1'b0;
            end else begin
                m_t++;
                for (int j = SS + 1; j > 0; j--) smp[j] = smp[j-1];
                smp[0] = din;
                m_rise = smp[SS] && !smp[SS+1];
                m_fall = !smp[SS] && smp[SS+1];
`ifdef BLINK_METER_TIMEOUT_EN
                m_lim = int'({toh, tol});
`endif
                e_intr = 1'b0;
                if (!en) begin
                    m_dis = 1'b1; m_hr = 1'b0; m_hf = 1'b0; e_to = 1'b0;
                end else if (m_dis) begin
                    m_dis = 1'b0;
                end else if (m_rise) begin
                    if (m_hr && m_hf) begin
                        e_hi = 32'(m_f - m_r); e_lo = 32'(m_t - m_f);
                        e_intr = 1'b1; e_to = 1'b0;
                    end
                    m_hr = 1'b1; m_hf = 1'b0; m_r = m_t;
                end else if (m_fall) begin
                    if (m_hr) begin m_hf = 1'b1; m_f = m_t; end
                end else if (m_hr && m_lim != 0 && m_t == (m_hf ? m_f : m_r) + m_lim) begin
                    e_intr = 1'b1; e_to = 1'b1; m_hr = 1'b0; m_hf = 1'b0;
                end
            end
        end
    end

    function automatic logic [65:0] obs_vec();
        logic t;
        t = 1'b0;
`ifdef BLINK_METER_TIMEOUT_EN
        t = tof;
`endif
        return {hth, htl, lth, ltl, intr, t};
    endfunction

    function automatic logic [65:0] exp_vec();
        return {e_hi, e_lo, e_intr, e_to};
    endfunction

    bit q_en[$];
    bit q_in[$];

    task automatic push(input bit e, input bit v, input int n);
        repeat (n) begin q_en.push_back(e); q_in.push_back(v); end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; din = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (obs_vec() !== 66'd0) begin
            n_fail++; $display("FAIL reset_values: got %h want 0", obs_vec());
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL reset_idle: got %h want %h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_basic();
        int icnt = 0, ipos = -1;
        push(0,0,3); push(1,0,3); push(1,0,4); push(1,1,5); push(1,0,3); push(1,1,5); push(1,0,5);
        for (int i = 0; q_en.size() > 0; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL basic it%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (intr === 1'b1) begin icnt++; if (ipos < 0) ipos = i; end
            en = q_en.pop_front(); din = q_in.pop_front();
        end
        n_tests++;
        if ({hth, htl} !== 32'd5 || {lth, ltl} !== 32'd3 || icnt != 1 || ipos != 21) begin
            n_fail++;
            $display("FAIL basic_result: got hi=%0d lo=%0d intrs=%0d at=%0d want 5 3 1 21",
                     {hth, htl}, {lth, ltl}, icnt, ipos);
        end
    endtask

    task automatic test_high_at_enable();
        int icnt = 0, ipos = -1;
        push(0,1,4); push(1,1,4); push(1,0,2); push(1,1,7); push(1,0,6); push(1,1,5); push(1,0,4);
        for (int i = 0; q_en.size() > 0; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL high_at_en it%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (intr === 1'b1) begin icnt++; if (ipos < 0) ipos = i; end
            en = q_en.pop_front(); din = q_in.pop_front();
        end
        n_tests++;
        if ({hth, htl} !== 32'd7 || {lth, ltl} !== 32'd6 || icnt != 1 || ipos != 26) begin
            n_fail++;
            $display("FAIL high_at_en_result: got hi=%0d lo=%0d intrs=%0d at=%0d want 7 6 1 26",
                     {hth, htl}, {lth, ltl}, icnt, ipos);
        end
    endtask

    task automatic test_back_to_back();
        int icnt = 0;
        push(0,0,2); push(1,0,3);
        repeat (10) begin push(1,1,1); push(1,0,1); end
        push(1,0,4);
        for (int i = 0; q_en.size() > 0; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL toggle it%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (intr === 1'b1) icnt++;
            en = q_en.pop_front(); din = q_in.pop_front();
        end
        n_tests++;
        if ({hth, htl} !== 32'd1 || {lth, ltl} !== 32'd1 || icnt != 9) begin
            n_fail++;
            $display("FAIL toggle_result: got hi=%0d lo=%0d intrs=%0d want 1 1 9",
                     {hth, htl}, {lth, ltl}, icnt);
        end
    endtask

    task automatic test_enable_drop();
        int icnt = 0;
        push(0,0,2); push(1,0,3); push(1,1,4); push(1,0,3); push(0,0,1);
        push(1,0,4); push(1,1,3); push(1,0,2); push(1,1,5); push(1,0,4);
        for (int i = 0; q_en.size() > 0; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL en_drop it%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i == 13) begin
                n_tests++;
                if ({hth, htl, lth, ltl, intr} !== {32'd1, 32'd1, 1'b0}) begin
                    n_fail++; $display("FAIL en_drop_hold: got %h want 1/1 no intr", {hth, htl, lth, ltl, intr});
                end
            end
            if (intr === 1'b1) icnt++;
            en = q_en.pop_front(); din = q_in.pop_front();
        end
        n_tests++;
        if ({hth, htl} !== 32'd3 || {lth, ltl} !== 32'd2 || icnt != 1) begin
            n_fail++;
            $display("FAIL en_drop_result: got hi=%0d lo=%0d intrs=%0d want 3 2 1",
                     {hth, htl}, {lth, ltl}, icnt);
        end
    endtask

`ifdef BLINK_METER_TIMEOUT_EN
    task automatic test_timeout();
        int icnt = 0, ipos = -1;
        logic [64:0] cap = '0;
        toh = 16'd0; tol = 16'd16;
        push(0,0,2); push(1,0,3); push(1,1,40); push(1,0,3); push(1,1,4); push(1,0,2); push(1,1,3); push(1,0,4);
        for (int i = 0; q_en.size() > 0; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL timeout it%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (intr === 1'b1) begin
                icnt++;
                if (ipos < 0) begin ipos = i; cap = {hth, htl, lth, ltl, tof}; end
            end
            en = q_en.pop_front(); din = q_in.pop_front();
        end
        n_tests++;
        if (ipos != 24 || cap !== {32'd3, 32'd2, 1'b1}) begin
            n_fail++; $display("FAIL timeout_event: got at=%0d state=%h want at=24 3/2 flag", ipos, cap);
        end
        n_tests++;
        if ({hth, htl} !== 32'd4 || {lth, ltl} !== 32'd2 || icnt != 2 || tof !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: got hi=%0d lo=%0d intrs=%0d to=%b want 4 2 2 0",
                     {hth, htl}, {lth, ltl}, icnt, tof);
        end
        tol = 16'd0;
    endtask
`endif

    task automatic test_async_reset();
        int icnt = 0;
        push(0,0,2); push(1,0,3); push(1,1,4); push(1,0,3); push(1,1,5); push(1,0,2); push(1,1,6);
        for (int i = 0; q_en.size() > 0; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL pre_reset it%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            en = q_en.pop_front(); din = q_in.pop_front();
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (obs_vec() !== 66'd0) begin
            n_fail++; $display("FAIL async_reset: got %h want 0", obs_vec());
        end
        @(negedge clk);
        rst = 1'b0;
        push(1,1,3); push(1,0,3); push(1,1,2); push(1,0,2); push(1,1,2); push(1,0,3);
        for (int i = 0; q_en.size() > 0; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL post_reset it%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (intr === 1'b1) icnt++;
            en = q_en.pop_front(); din = q_in.pop_front();
        end
        n_tests++;
        if ({hth, htl} !== 32'd2 || {lth, ltl} !== 32'd2 || icnt != 2) begin
            n_fail++;
            $display("FAIL post_reset_result: got hi=%0d lo=%0d intrs=%0d want 2 2 2",
                     {hth, htl}, {lth, ltl}, icnt);
        end
    endtask

    task automatic test_random();
        bit lvl;
        lvl = din;
`ifdef BLINK_METER_TIMEOUT_EN
        tol = 16'($urandom_range(6, 20));
`endif
        push(0, lvl, 2);
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 9) == 0) begin
                push(0, lvl, int'($urandom_range(1, 3)));
            end else begin
                lvl = ~lvl;
                push(1, lvl, ($urandom_range(0, 7) == 0) ? 25 : int'($urandom_range(1, 8)));
            end
        end
        push(1, lvl, 6);
        for (int i = 0; q_en.size() > 0; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random it%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            en = q_en.pop_front(); din = q_in.pop_front();
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_high_at_enable();
        test_back_to_back();
        test_enable_drop();
`ifdef BLINK_METER_TIMEOUT_EN
        test_timeout();
`endif
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
